// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and ALU-side signals for alu_arbiter.
// Handshake rule: a transfer happens in a cycle where valid and ready are both high; a requester keeps payload stable while valid is high and ready is low.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;

    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    logic        busy;
    logic [1:0]  dbg_state;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, alu_result,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_data, rsp_err, alu_op, alu_a, alu_b, busy, dbg_state
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, alu_result,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_data, rsp_err, alu_op, alu_a, alu_b, busy, dbg_state
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for a shared combinational 32-bit ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module alu_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [2:0] OP_RSVD = 3'b011;

    logic [1:0]  r_state;
    logic        r_owner;
    logic [2:0]  r_alu_op;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_any_valid;
    logic        w_grant;
    logic        w_accept;
    logic        w_rsp_hs;

    assign w_any_valid = bus.req0_valid | bus.req1_valid;

`ifdef ALU_ARB_RR_EN
    logic r_last_grant;

    // On a tie, favour whichever requester was not served last.
    always_comb begin
        w_grant = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = ~r_last_grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
        end
    end
`else
    // Requester 1 only wins when requester 0 is idle; w_accept masks the no-valid case.
    assign w_grant = ~bus.req0_valid;
`endif

    assign w_accept = (r_state == S_IDLE) && w_any_valid;
    assign w_rsp_hs = (r_state == S_RESP) && (r_owner ? bus.rsp1_ready : bus.rsp0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_EXEC;
                        r_owner <= w_grant;
                    end
                end
                S_EXEC: r_state <= S_RESP;
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ALU operands only load on accept, so they hold their value outside EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_op <= 3'd0;
            r_alu_a  <= 32'd0;
            r_alu_b  <= 32'd0;
        end else if (w_accept) begin
            r_alu_op <= w_grant ? bus.req1_op : bus.req0_op;
            r_alu_a  <= w_grant ? bus.req1_a  : bus.req0_a;
            r_alu_b  <= w_grant ? bus.req1_b  : bus.req0_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 1'b0;
        end else if (r_state == S_EXEC) begin
            if (r_alu_op == OP_RSVD) begin
                r_rsp_data <= 32'd0;
                r_rsp_err  <= 1'b1;
            end else begin
                r_rsp_data <= bus.alu_result;
                r_rsp_err  <= 1'b0;
            end
        end
    end

    assign bus.req0_ready = w_accept && !w_grant;
    assign bus.req1_ready = w_accept &&  w_grant;
    assign bus.rsp0_valid = (r_state == S_RESP) && !r_owner;
    assign bus.rsp1_valid = (r_state == S_RESP) &&  r_owner;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.alu_op     = r_alu_op;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-plus-random bench for alu_arbiter with a behavioural ALU and grant/response reference model.
// Honours ALU_ARB_RR_EN the same way the design does.
module tb_alu_arbiter;

    logic clk;
    logic rst_n;
    alu_arbiter_if bus();

    alu_arbiter u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q[$];
    int order[$];
    int model_last = 1;
    logic [2:0]  cur_op;
    logic [31:0] cur_a;
    logic [31:0] cur_b;

    function automatic logic [31:0] alu_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b100:  return ~a;
            3'b101:  return ~(a | b);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign bus.alu_result = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

    function automatic logic [32:0] expected_rsp(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        if (op == 3'b011) return {1'b1, 32'd0};
        return {1'b0, alu_model(op, a, b)};
    endfunction

    function automatic int expected_grant(logic v0, logic v1);
        if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
            return 1 - model_last;
`else
            return 0;
`endif
        end
        return v0 ? 0 : 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input int g, input logic v);
        if (g == 0) bus.req0_valid = v;
        else        bus.req1_valid = v;
    endtask

    task automatic set_rsp_ready(input int g, input logic v);
        if (g == 0) bus.rsp0_ready = v;
        else        bus.rsp1_ready = v;
    endtask

    task automatic drive_req(input int g, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (g == 0) begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end
    endtask

    task automatic random_req(input int g);
        drive_req(g, 3'($urandom_range(0, 7)), $urandom, $urandom);
    endtask

    function automatic logic rspv(input int g);
        return (g == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction

    // Polls for a grant; on accept records the reference response and grant order.
    task automatic wait_grant(output int g, output int waited);
        g = -1;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                int eg;
                eg = expected_grant(bus.req0_valid, bus.req1_valid);
                g = bus.req1_ready ? 1 : 0;
                check("single_ready", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
                check("grant_owner", 64'(g), 64'(eg));
                model_last = g;
                cur_op = (g == 1) ? bus.req1_op : bus.req0_op;
                cur_a  = (g == 1) ? bus.req1_a  : bus.req0_a;
                cur_b  = (g == 1) ? bus.req1_b  : bus.req0_b;
                exp_q.push_back(expected_rsp(cur_op, cur_a, cur_b));
                order.push_back(g);
                return;
            end
            @(negedge clk);
            waited++;
        end
        check("grant_timeout", 64'd1, 64'd0);
    endtask

    // other_mode: 0 leave other requester alone, 1 pulse its valid during RESP, 2 raise it in EXEC.
    task automatic finish_op(input int g, input int hold, input bit keep, input int other_mode);
        logic [32:0] e;
        if (g < 0) return;
        @(negedge clk);
        if (keep) random_req(g);
        else      set_valid(g, 1'b0);
        if (other_mode == 2) random_req(1 - g);
        #1;
        check("exec_busy", 64'(bus.busy), 64'd1);
        check("exec_alu_op", 64'(bus.alu_op), 64'(cur_op));
        check("exec_alu_a", 64'(bus.alu_a), 64'(cur_a));
        check("exec_alu_b", 64'(bus.alu_b), 64'(cur_b));
        check("exec_rsp_valid", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
        check("exec_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
        @(negedge clk);
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
        check("rsp_valid_owner", 64'(rspv(g)), 64'd1);
        check("rsp_valid_other", 64'(rspv(1 - g)), 64'd0);
        check("rsp_data", 64'(bus.rsp_data), 64'(e[31:0]));
        check("rsp_err", 64'(bus.rsp_err), 64'(e[32]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (other_mode == 1 && i == 0) random_req(1 - g);
            if (other_mode == 1 && i == 1) set_valid(1 - g, 1'b0);
            #1;
            check("hold_rsp_valid", 64'(rspv(g)), 64'd1);
            check("hold_rsp_data", 64'(bus.rsp_data), 64'(e[31:0]));
            check("hold_rsp_err", 64'(bus.rsp_err), 64'(e[32]));
            check("hold_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
            check("hold_busy", 64'(bus.busy), 64'd1);
            check("hold_alu_a", 64'(bus.alu_a), 64'(cur_a));
        end
        if (other_mode == 1) set_valid(1 - g, 1'b0);
        set_rsp_ready(g, 1'b1);
        @(negedge clk);
        set_rsp_ready(g, 1'b0);
        #1;
        check("post_rsp_valid", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
        check("post_busy", 64'(bus.busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
        check({tag, "_rsp_valid"}, 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
        check({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'd0);
        check({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
        check({tag, "_alu_op"}, 64'(bus.alu_op), 64'd0);
        check({tag, "_alu_a"}, 64'(bus.alu_a), 64'd0);
        check({tag, "_alu_b"}, 64'(bus.alu_b), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int w;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
        bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

        // Power-on reset
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single ADD 5 + 3
        drive_req(0, 3'b010, 32'h0000_0005, 32'h0000_0003);
        wait_grant(g, w);
        check("add_ready_first_cycle", 64'(w), 64'd0);
        check("add_expected_8", 64'(exp_q.size() > 0 ? exp_q[0][31:0] : 32'd0), 64'd8);
        finish_op(g, 0, 1'b0, 0);

        // Reserved op from requester 1
        drive_req(1, 3'b011, 32'hFFFF_FFFF, $urandom);
        wait_grant(g, w);
        finish_op(g, 1, 1'b0, 0);

        // Backpressure on rsp1 with req0 waiting
        random_req(1);
        wait_grant(g, w);
        check("bp_owner", 64'(g), 64'd1);
        finish_op(g, 5, 1'b0, 2);
        wait_grant(g, w);
        check("bp_next_owner", 64'(g), 64'd0);
        check("bp_accept_next_cycle", 64'(w), 64'd0);
        finish_op(g, 0, 1'b0, 0);

        // Withdrawn request during RESP
        random_req(1);
        wait_grant(g, w);
        finish_op(g, 3, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("withdraw_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
            check("withdraw_rsp_valid", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
            check("withdraw_busy", 64'(bus.busy), 64'd0);
        end

        // Random single-requester traffic
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            random_req(int'($urandom_range(0, 1)));
            wait_grant(g, w);
            finish_op(g, int'($urandom_range(0, 3)), 1'b0, 0);
        end

        // Reset asserted while the operation is in EXEC
        @(negedge clk);
        random_req(0);
        wait_grant(g, w);
        @(negedge clk);
        set_valid(0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_exec_state", 64'(bus.dbg_state), 64'd0);
        check_all_zero("rst_exec");
        exp_q.delete();
        model_last = 1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check("rst_idle_busy", 64'(bus.busy), 64'd0);
            check("rst_idle_rsp", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
        end

        // Tie: both requesters keep valid high across four operations
        @(negedge clk);
        order.delete();
        random_req(0);
        random_req(1);
        for (int i = 0; i < 4; i++) begin
            wait_grant(g, w);
            finish_op(g, int'($urandom_range(0, 2)), 1'b1, 0);
        end
        set_valid(0, 1'b0);
        set_valid(1, 1'b0);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
            check("tie_order", 64'(order.size() > i ? order[i] : -1), 64'(i % 2));
`else
            check("tie_order", 64'(order.size() > i ? order[i] : -1), 64'd0);
`endif
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
